alu_cpsr_stage: RTL

Registered execute stage downstream of the 32-bit barrel shifter. Takes Rn and the shifter's operand-2 result and carry, and performs one of the 16 ARM data-processing operations. Holds the CPSR condition flags (NZCV) and feeds the C flag back to the shifter's `Carry_flag` input. Results leave through a single-entry valid/ready output register.

---
 rtl/alu_cpsr_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_cpsr_stage.sv
// Registered ARM data-processing execute stage: 16-op ALU, CPSR NZCV flags with
// C fed back to the barrel shifter, and a single-entry valid/ready result register.
module alu_cpsr_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] Shift_out,
    input  logic        Shift_carry_out,
    input  logic [3:0]  ALU_OP,
    input  logic        S,
    input  logic        Flags_we,
    input  logic [3:0]  Flags_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] F,
    output logic        Write_Rd,
    output logic [3:0]  NZCV,
    output logic        Carry_flag
);

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    alu_op_e     op;
    logic        is_test;
    logic        s_eff;
    logic        carry_in;
    logic        accept;

    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic        is_arith;
    logic [32:0] sum;
    logic [31:0] logic_res;
    logic [31:0] result;
    flags_t      alu_flags;

    logic        out_valid_q, out_valid_d;
    logic [31:0] f_q,         f_d;
    logic        write_rd_q,  write_rd_d;
    flags_t      nzcv_q,      nzcv_d;

    assign op       = alu_op_e'(ALU_OP);
    // TST/TEQ/CMP/CMN occupy 8..B: they always set flags and never write Rd.
    assign is_test  = (ALU_OP[3:2] == 2'b10);
    assign s_eff    = S | is_test;
    assign carry_in = nzcv_q.c;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Adder operand selection; subtracts invert one operand so C means NOT borrow.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        add_x    = A;
        add_y    = Shift_out;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (op)
            OP_ADD, OP_CMN: add_cin = 1'b0;
            OP_ADC:         add_cin = carry_in;
            OP_SUB, OP_CMP: begin
                add_y   = ~Shift_out;
                add_cin = 1'b1;
            end
            OP_SBC: begin
                add_y   = ~Shift_out;
                add_cin = carry_in;
            end
            OP_RSB: begin
                add_x   = Shift_out;
                add_y   = ~A;
                add_cin = 1'b1;
            end
            OP_RSC: begin
                add_x   = Shift_out;
                add_y   = ~A;
                add_cin = carry_in;
            end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    always_comb begin
        logic_res = A & Shift_out;
        case (op)
            OP_AND, OP_TST: logic_res = A & Shift_out;
            OP_EOR, OP_TEQ: logic_res = A ^ Shift_out;
            OP_ORR:         logic_res = A | Shift_out;
            OP_MOV:         logic_res = Shift_out;
            OP_BIC:         logic_res = A & ~Shift_out;
            OP_MVN:         logic_res = ~Shift_out;
            default:        logic_res = A & Shift_out;
        endcase
    end

    assign result = is_arith ? sum[31:0] : logic_res;

    always_comb begin
        alu_flags.n = result[31];
        alu_flags.z = (result == 32'd0);
        alu_flags.c = Shift_carry_out;
        alu_flags.v = nzcv_q.v;
        if (is_arith) begin
            alu_flags.c = sum[32];
            alu_flags.v = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
        end
    end

    // A direct flag load overrides any ALU flag update on the same edge.
    always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        write_rd_d  = write_rd_q;
        nzcv_d      = nzcv_q;
        if (accept) begin
            out_valid_d = 1'b1;
            f_d         = result;
            write_rd_d  = !is_test;
            if (s_eff) begin
                nzcv_d = alu_flags;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (Flags_we) begin
            nzcv_d = flags_t'(Flags_in);
        end
    end

    // NOTE: the result register is reset as well as the control bits, so F reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= 32'd0;
            write_rd_q  <= 1'b0;
            nzcv_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            write_rd_q  <= write_rd_d;
            nzcv_q      <= nzcv_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign F          = f_q;
    assign Write_Rd   = write_rd_q;
    assign NZCV       = nzcv_q;
    assign Carry_flag = nzcv_q.c;

    stall_holds_result: assert property (
        @(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(F) && $stable(Write_Rd)
    );

endmodule
